button_events: RTL and testbench
================================

# button_events

Converts the debounced button level into single-cycle event pulses for the stepper control logic: press, release, long-press and auto-repeat. It sits directly downstream of the button debouncer, takes its filtered output as `in`, and feeds jog/step requests to the motion controller. A small state machine plus a tick counter measure hold time, and an 8-bit counter tallies presses.

## Interface
- `LONG_TICKS`, 1000: hold time, in clock cycles, from `r_press` to `r_long`; legal range ≥ 2.
- `REPEAT_TICKS`, 250: period, in clock cycles, of `r_repeat` while in LONG; legal range ≥ 2.
- `ACTIVE_HIGH`, 1: 1 means `in`=1 is pressed; 0 means `in`=0 is pressed.
- `clk_in` input 1: the single clock; all logic is on its rising edge.
- `rst_in` input 1: reset, synchronous and active-high.
- `in` input 1: debounced button level.
- `r_press` output 1: one-cycle pulse on a press.
- `r_release` output 1: one-cycle pulse on a release.
- `r_long` output 1: one-cycle pulse when the hold reaches `LONG_TICKS`.
- `r_repeat` output 1: one-cycle pulse every `REPEAT_TICKS` cycles while in LONG.
- `r_held` output 1: level, high while the state is SHORT or LONG.
- `r_press_cnt` output 8: count of presses; wraps modulo 256.

## Operation
- Normalized level: `lvl = ACTIVE_HIGH ? in : ~in`. A register `r_prev` holds the `lvl` value from the previous cycle.
- Tick counter width: `$clog2(max(LONG_TICKS, REPEAT_TICKS)) + 1` bits. It is cleared on every state change.
- State IDLE:
  - On `lvl`=1 and `r_prev`=0, go to SHORT, pulse `r_press`, and increment `r_press_cnt`.
  - `lvl`=1 with `r_prev`=1 (stuck high) does not generate a press.
- State SHORT: the counter increments each cycle.
  - `lvl`=0: pulse `r_release` and go to IDLE.
  - Counter reaches the threshold with `lvl`=1: pulse `r_long` and go to LONG.
- State LONG: the counter increments each cycle.
  - When it reaches the repeat threshold, pulse `r_repeat` and clear the counter.
  - `lvl`=0: pulse `r_release` and go to IDLE.
- Simultaneous events: release takes priority. A cycle that sees `lvl`=0 and also hits the long or repeat threshold produces only `r_release`, never `r_long` or `r_repeat`.
- At most one of `r_press`, `r_release`, `r_long`, `r_repeat` is high in any cycle.
- Reset values: state IDLE, counter 0, `r_prev`=0, and every output 0.
- Reset mid-press: the press is aborted with no `r_release`.
- If the button is still pressed after reset deasserts: `r_prev`=0, so the first edge after reset sees a rising level and a press is reported.

## Timing
- Input to event latency is 1 cycle: `lvl` sampled at edge k gives a pulse registered at edge k, visible during cycle k..k+1.
- `r_long` rises exactly `LONG_TICKS` cycles after `r_press` rises, if the button stays held.
- The first `r_repeat` comes `REPEAT_TICKS` cycles after `r_long`, then every `REPEAT_TICKS` cycles after that.
- `r_held` rises in the same cycle as `r_press` and falls in the same cycle as `r_release`.
- `r_press_cnt` updates in the same cycle as `r_press`.
- Minimum press-to-press spacing is 2 cycles (one release cycle, then a new press).

## Configuration
- Macro: `BUTTON_EVENTS_AUTOREPEAT_EN`.
- Defined: LONG runs the repeat counter and emits `r_repeat` as described above.
- Undefined:
  - `r_repeat` is tied to 0.
  - LONG only waits for release.
  - `REPEAT_TICKS` is ignored.
  - The counter does not advance in LONG.
  - `r_long` and `r_release` behaviour is unchanged.

## Test plan
All scenarios use `LONG_TICKS`=10, `REPEAT_TICKS`=4, `ACTIVE_HIGH`=1.
- Reset with held button: `rst_in`=1 for 3 cycles with `in`=1 → all outputs 0 during reset; `r_press` pulses 1 cycle after the first post-reset edge; `r_press_cnt`=1.
- Short press: `in`=1 for 5 cycles, then 0 → `r_press` ×1, `r_held` high 5 cycles, `r_release` ×1, no `r_long`, `r_press_cnt`=1.
- Long hold with repeat: `in`=1 held for 28 cycles after `r_press` → `r_long` at press+10; `r_repeat` at press+14, +18, +22, +26; `r_release` at press+28.
- Release on the threshold: `in` drops so that `lvl`=0 is sampled on the cycle that would fire `r_long` → only `r_release`, no `r_long`, state IDLE.
- Counter wrap: 256 short presses of 3 cycles each, separated by 2 idle cycles → `r_press_cnt` reads 255, then 0 after the 256th press.
- Macro undefined: same 28-cycle hold as above → `r_long` once at press+10, zero `r_repeat` pulses, `r_release` at press+28.

Source files
------------

// File: rtl/button_events.sv
// Turns a debounced button level into press/release/long-press/auto-repeat pulses.
// Define BUTTON_EVENTS_AUTOREPEAT_EN to enable the auto-repeat pulses while in LONG.
module button_events #(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250,
  parameter bit ACTIVE_HIGH  = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       in,
  output logic       r_press,
  output logic       r_release,
  output logic       r_long,
  output logic       r_repeat,
  output logic       r_held,
  output logic [7:0] r_press_cnt
);

  localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS) + 1;
  // Thresholds are compared against the pre-increment count, hence the minus one.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lvl, r_prev;
  logic          press_nxt, release_nxt, long_nxt;

  assign lvl = ACTIVE_HIGH ? in : ~in;

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
  logic repeat_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    repeat_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (lvl && !r_prev) begin
          state_nxt = SHORT;
          press_nxt = 1'b1;
          cnt_nxt   = '0;
        end
      end
      SHORT: begin
        // Release is checked first so it wins over a coincident threshold.
        if (!lvl) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          cnt_nxt     = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG;
          long_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LONG: begin
        if (!lvl) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          cnt_nxt     = '0;
        end
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
        else if (cnt == REPEAT_LAST) begin
          repeat_nxt = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      r_prev      <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_held      <= 1'b0;
      r_press_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      r_prev    <= lvl;
      r_press   <= press_nxt;
      r_release <= release_nxt;
      r_long    <= long_nxt;
      r_held    <= (state_nxt != IDLE);
      if (press_nxt) begin
        r_press_cnt <= r_press_cnt + 8'd1;
      end
    end
  end

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= repeat_nxt;
    end
  end
`else
  assign r_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_events.sv
// Randomized bench for button_events, compared each cycle against a hold-age reference model.
module tb_button_events;

  localparam int LT = 10;
  localparam int RT = 4;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_in, in;
  logic       r_press, r_release, r_long, r_repeat, r_held;
  logic [7:0] r_press_cnt;

  button_events #(.LONG_TICKS(LT), .REPEAT_TICKS(RT), .ACTIVE_HIGH(1'b1)) dut (
    .clk_in(clk), .rst_in(rst_in), .in(in),
    .r_press(r_press), .r_release(r_release), .r_long(r_long),
    .r_repeat(r_repeat), .r_held(r_held), .r_press_cnt(r_press_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a press flag plus the number of cycles since the press edge.
  bit       m_pressed, m_prev;
  int       m_age;
  bit       m_press, m_release, m_long, m_repeat;
  bit [7:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic i, input logic r);
    m_press = 0; m_release = 0; m_long = 0; m_repeat = 0;
    if (r) begin
      m_pressed = 0; m_prev = 0; m_age = 0; m_cnt = 0;
    end else begin
      if (!m_pressed) begin
        if (i && !m_prev) begin
          m_press = 1; m_pressed = 1; m_age = 0; m_cnt = m_cnt + 8'd1;
        end
      end else begin
        m_age++;
        if (!i) begin
          m_release = 1; m_pressed = 0;
        end else if (m_age == LT) begin
          m_long = 1;
        end else if (AR && m_age > LT && ((m_age - LT) % RT) == 0) begin
          m_repeat = 1;
        end
      end
      m_prev = i;
    end
  endtask

  task automatic cycle(input logic i, input logic r);
    in = i;
    rst_in = r;
    @(posedge clk);
    model_step(i, r);
    @(negedge clk);
    check("events", {r_press, r_release, r_long, r_repeat, r_held},
          {m_press, m_release, m_long, m_repeat, m_pressed});
    check("press_cnt", r_press_cnt, m_cnt);
    check("one_event", 32'($countones({r_press, r_release, r_long, r_repeat}) <= 1), 1);
  endtask

  initial begin
    in = 1'b0;
    rst_in = 1'b1;
    m_pressed = 0; m_prev = 0; m_age = 0; m_cnt = 0;
    @(negedge clk);

    // Reset with the button held, then a 28-cycle hold with long/repeat.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    check("press_after_reset", r_press, 1);
    check("cnt_after_reset", r_press_cnt, 1);
    for (int k = 0; k < 27; k++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("release_at_28", r_release, 1);
    cycle(1'b0, 1'b0);

    // Short press of 5 cycles.
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    // Release sampled on the cycle that would fire the long pulse.
    for (int k = 0; k < LT; k++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("thresh_release", {r_release, r_long, r_held}, 3'b100);
    cycle(1'b0, 1'b0);

    // Press counter wrap.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    for (int p = 1; p <= 256; p++) begin
      if (p == 256) check("cnt_255", r_press_cnt, 255);
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0);
      for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0);
    end
    check("cnt_wrap_0", r_press_cnt, 0);

    // Random holds, gaps, glitches and occasional resets.
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        int nr = $urandom_range(1, 3);
        for (int k = 0; k < nr; k++) cycle(1'($urandom_range(0, 1)), 1'b1);
      end
      begin
        int hold = $urandom_range(1, 40);
        int gap  = $urandom_range(1, 4);
        for (int k = 0; k < hold; k++) cycle(1'b1, 1'b0);
        for (int k = 0; k < gap; k++) cycle(1'b0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
